stripe_pattern_detector: RTL and testbench

STRIPE_PATTERN_DETECTOR -- requirements
Module: stripe_pattern_detector

---
 rtl/stripe_pkg.sv | 22 ++
 rtl/stripe_pattern_detector_if.sv | 22 ++
 rtl/run_length_classifier.sv | 60 ++++++
 rtl/stripe_pattern_detector.sv | 156 +++++++++++++++
 tb/tb_stripe_pattern_detector.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/stripe_pkg.sv
// Shared types and constants for the stripe pattern detector.
// Per-row stripe counter width, stripe polarity encoding and the frame result record.
package stripe_pkg;

  localparam int STRIPE_CNT_W = 8;
  localparam int RES_ROWS_W   = 16;

  localparam logic [STRIPE_CNT_W-1:0] STRIPE_CNT_MAX = '1;

  typedef enum logic {
    MODE_BRIGHT = 1'b0,
    MODE_DARK   = 1'b1
  } mode_e;

  // stripe_rows is stored wide here and narrowed to the frame height at the top level
  typedef struct packed {
    logic                    crossing_detected;
    logic [RES_ROWS_W-1:0]   stripe_rows;
    logic [STRIPE_CNT_W-1:0] max_stripes;
  } result_t;

endpackage

// File: rtl/stripe_pattern_detector_if.sv
// Pixel-in / mask-out valid-ready stream pair for the stripe pattern detector.
// master = stream source and mask sink, slave = detector.
interface stripe_pattern_detector_if #(
  parameter int W = 8
);
  logic         x_valid;
  logic         x_ready;
  logic [W-1:0] x_data;
  logic         y_valid;
  logic         y_ready;
  logic [W-1:0] y_data;

  modport master (
    output x_valid, x_data, y_ready,
    input  x_ready, y_valid, y_data
  );

  modport slave (
    input  x_valid, x_data, y_ready,
    output x_ready, y_valid, y_data
  );
endinterface

// File: rtl/run_length_classifier.sv
// Per-row run-length tracker: counts runs of hits and the qualifying stripes of the row.
// row_stripes is combinational and includes the run closed by the current pixel.
module run_length_classifier
  import stripe_pkg::*;
#(
  parameter int MIN_RUN = 8,
  parameter int MAX_RUN = 200
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    pix_stb,
  input  logic                    hit,
  input  logic                    row_end,
  output logic [STRIPE_CNT_W-1:0] row_stripes
);

  localparam int                RUN_W   = $clog2(MAX_RUN + 2);
  localparam logic [RUN_W-1:0]  RUN_SAT = RUN_W'(MAX_RUN + 1);

  logic [RUN_W-1:0]        run_len;
  logic [RUN_W-1:0]        run_base;
  logic [RUN_W-1:0]        run_inc;
  logic [RUN_W-1:0]        close_len;
  logic [STRIPE_CNT_W-1:0] stripes_q;
  logic [STRIPE_CNT_W-1:0] stripes_base;
  logic                    closes;
  logic                    qual;

  // A clear in the same cycle as a pixel makes that pixel start from an empty row.
  always_comb begin
    run_base     = clear ? '0 : run_len;
    stripes_base = clear ? '0 : stripes_q;
    run_inc      = (run_base == RUN_SAT) ? run_base : run_base + RUN_W'(1);
    close_len    = hit ? run_inc : run_base;
    closes       = pix_stb && (!hit || row_end);
    qual         = closes && (int'(close_len) >= MIN_RUN) && (int'(close_len) <= MAX_RUN);
    row_stripes  = (qual && (stripes_base != STRIPE_CNT_MAX))
                 ? stripes_base + STRIPE_CNT_W'(1) : stripes_base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_len   <= '0;
      stripes_q <= '0;
    end else if (pix_stb) begin
      if (row_end) begin
        run_len   <= '0;
        stripes_q <= '0;
      end else begin
        run_len   <= hit ? run_inc : '0;
        stripes_q <= row_stripes;
      end
    end else if (clear) begin
      run_len   <= '0;
      stripes_q <= '0;
    end
  end

endmodule

// File: rtl/stripe_pattern_detector.sv
// Thresholds a raster pixel stream into a hit mask and counts rows holding enough
// bounded-length stripes; a frame summary is published one cycle after its last pixel.
module stripe_pattern_detector
  import stripe_pkg::*;
#(
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int W           = 8,
  parameter int MIN_RUN     = 8,
  parameter int MAX_RUN     = 200,
  parameter int MIN_STRIPES = 3,
  parameter int MIN_ROWS    = 20
) (
  input  logic                            clk,
  input  logic                            rst,
  stripe_pattern_detector_if.slave        bus,
  input  logic [W-1:0]                    threshold,
  input  logic                            mode,
  input  logic                            frame_restart,
  output logic                            detection_valid,
  output logic                            crossing_detected,
  output logic [$clog2(IMG_HEIGHT+1)-1:0] stripe_rows,
  output logic [STRIPE_CNT_W-1:0]         max_stripes
);

  localparam int CW  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int HW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int RCW = $clog2(IMG_HEIGHT + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [HW-1:0] ROW_LAST = HW'(IMG_HEIGHT - 1);

  logic [CW-1:0]           col, col_eff;
  logic [HW-1:0]           row, row_eff;
  logic [W-1:0]            thr_q, thr_eff;
  mode_e                   mode_q, mode_eff;
  logic                    accept, first_pix, hit, row_end, frame_end;
  logic                    y_valid_q;
  logic [W-1:0]            y_data_q;
  logic                    det_q;
  logic [STRIPE_CNT_W-1:0] row_stripes;
  logic [RCW-1:0]          rows_acc, rows_base, rows_next;
  logic [STRIPE_CNT_W-1:0] max_acc, max_base, max_next;
  logic                    row_qual;
  result_t                 res_q, res_next;

  assign bus.x_ready = !y_valid_q || bus.y_ready;
  assign bus.y_valid = y_valid_q;
  assign bus.y_data  = y_data_q;
  assign accept      = bus.x_valid && bus.x_ready;

  // A restart cycle behaves as if the position counters already read (0,0).
  always_comb begin
    col_eff   = frame_restart ? '0 : col;
    row_eff   = frame_restart ? '0 : row;
    first_pix = (col_eff == '0) && (row_eff == '0);
    thr_eff   = first_pix ? threshold : thr_q;
    mode_eff  = first_pix ? mode_e'(mode) : mode_q;
    hit       = (mode_eff == MODE_DARK) ? (bus.x_data < thr_eff) : (bus.x_data >= thr_eff);
    row_end   = accept && (col_eff == COL_LAST);
    frame_end = row_end && (row_eff == ROW_LAST);
  end

  run_length_classifier #(
    .MIN_RUN (MIN_RUN),
    .MAX_RUN (MAX_RUN)
  ) u_rlc (
    .clk         (clk),
    .rst         (rst),
    .clear       (frame_restart),
    .pix_stb     (accept),
    .hit         (hit),
    .row_end     (row_end),
    .row_stripes (row_stripes)
  );

  always_comb begin
    rows_base = frame_restart ? '0 : rows_acc;
    max_base  = frame_restart ? '0 : max_acc;
    row_qual  = int'(row_stripes) >= MIN_STRIPES;
    rows_next = rows_base + RCW'(row_qual);
    max_next  = (row_stripes > max_base) ? row_stripes : max_base;
    res_next                   = '0;
    res_next.crossing_detected = int'(rows_next) >= MIN_ROWS;
    res_next.stripe_rows       = RES_ROWS_W'(rows_next);
    res_next.max_stripes       = max_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      thr_q     <= '0;
      mode_q    <= MODE_BRIGHT;
      rows_acc  <= '0;
      max_acc   <= '0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      det_q     <= 1'b0;
      res_q     <= '0;
    end else begin
      det_q <= frame_end;

      if (accept) begin
        y_valid_q <= 1'b1;
        y_data_q  <= hit ? '1 : '0;
      end else if (bus.y_ready) begin
        y_valid_q <= 1'b0;
      end

      if (accept) begin
        if (first_pix) begin
          thr_q  <= threshold;
          mode_q <= mode_e'(mode);
        end
        if (col_eff == COL_LAST) begin
          col <= '0;
          row <= (row_eff == ROW_LAST) ? '0 : row_eff + HW'(1);
        end else begin
          col <= col_eff + CW'(1);
          row <= row_eff;
        end
      end else if (frame_restart) begin
        col <= '0;
        row <= '0;
      end

      if (row_end) begin
        if (frame_end) begin
          rows_acc <= '0;
          max_acc  <= '0;
          res_q    <= res_next;
        end else begin
          rows_acc <= rows_next;
          max_acc  <= max_next;
        end
      end else begin
        rows_acc <= rows_base;
        max_acc  <= max_base;
      end
    end
  end

  assign detection_valid   = det_q;
  assign crossing_detected = res_q.crossing_detected;
  assign stripe_rows       = res_q.stripe_rows[RCW-1:0];
  assign max_stripes       = res_q.max_stripes;

  generate
    if (RCW < RES_ROWS_W) begin : g_res_pad
      logic unused_res_pad;
      assign unused_res_pad = |res_q.stripe_rows[RES_ROWS_W-1:RCW];
    end
  endgenerate

endmodule

// File: tb/tb_stripe_pattern_detector.sv
// Directed bench for stripe_pattern_detector on a 16x4 frame with hand-computed results.
module tb_stripe_pattern_detector;

  localparam int IW   = 16;
  localparam int IH   = 4;
  localparam int NPIX = IW * IH;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] threshold = 8'h80;
  logic       mode = 1'b0;
  logic       frame_restart = 1'b0;
  logic       detection_valid;
  logic       crossing_detected;
  logic [2:0] stripe_rows;
  logic [7:0] max_stripes;

  stripe_pattern_detector_if #(.W(8)) bus ();

  stripe_pattern_detector #(
    .IMG_WIDTH   (IW),
    .IMG_HEIGHT  (IH),
    .W           (8),
    .MIN_RUN     (2),
    .MAX_RUN     (4),
    .MIN_STRIPES (2),
    .MIN_ROWS    (3)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .threshold         (threshold),
    .mode              (mode),
    .frame_restart     (frame_restart),
    .detection_valid   (detection_valid),
    .crossing_detected (crossing_detected),
    .stripe_rows       (stripe_rows),
    .max_stripes       (max_stripes)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc = 0;
  int         det_cnt = 0;
  int         det_cyc = 0;
  int         last_acc_cyc = 0;
  int         d0 = 0;
  logic [7:0] pix [NPIX];
  logic [7:0] yq [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.y_valid && bus.y_ready) yq.push_back(bus.y_data);
    if (detection_valid) begin
      det_cnt = det_cnt + 1;
      det_cyc = cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mask bit 15 is column 0; a set bit becomes FF (or 00 when inverted)
  task automatic set_frame(input logic [15:0] m0, input logic [15:0] mrest, input bit inv);
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        logic [15:0] m;
        m = (r == 0) ? m0 : mrest;
        pix[r*IW + c] = (m[15-c] ^ inv) ? 8'hFF : 8'h00;
      end
    end
  endtask

  task automatic send(input int n, input bit stall, input bit restart_first, input int flip_at);
    int  i = 0;
    int  guard = 0;
    bit  flipped = 1'b0;
    while (i < n && guard < 4000) begin
      bus.x_valid   = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.x_data    = pix[i];
      bus.y_ready   = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      frame_restart = restart_first && (i == 0);
      if (i == flip_at && !flipped) begin
        mode      = ~mode;
        threshold = 8'h10;
        flipped   = 1'b1;
      end
      @(negedge clk);
      if (bus.x_valid && bus.x_ready) begin
        i++;
        last_acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    bus.x_valid   = 1'b0;
    frame_restart = 1'b0;
    bus.y_ready   = 1'b1;
    if (i < n) check_eq("send_timeout", i, n);
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int e_rows, input int e_max, input bit e_cross,
                             input int det_before, input bit m, input logic [7:0] thr);
    int bad = 0;
    check_eq({tag, "_det_cnt"}, det_cnt - det_before, 1);
    check_eq({tag, "_det_lat"}, det_cyc - last_acc_cyc, 1);
    check_eq({tag, "_stripe_rows"}, stripe_rows, e_rows);
    check_eq({tag, "_max_stripes"}, max_stripes, e_max);
    check_eq({tag, "_crossing"}, crossing_detected, e_cross);
    check_eq({tag, "_ylen"}, yq.size(), NPIX);
    for (int k = 0; k < NPIX && k < yq.size(); k++) begin
      logic [7:0] e;
      e = (m ? (pix[k] < thr) : (pix[k] >= thr)) ? 8'hFF : 8'h00;
      if (yq[k] !== e) bad++;
    end
    check_eq({tag, "_ydata_bad"}, bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.x_valid = 1'b0;
    bus.x_data  = 8'h00;
    bus.y_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_y_valid", bus.y_valid, 0);
    check_eq("rst_y_data", bus.y_data, 0);
    check_eq("rst_x_ready", bus.x_ready, 1);
    check_eq("rst_det", detection_valid, 0);
    check_eq("rst_cross", crossing_detected, 0);
    check_eq("rst_rows", stripe_rows, 0);
    check_eq("rst_max", max_stripes, 0);
    @(posedge clk);
    #1;

    // two runs of 3 per row: every row qualifies
    set_frame(16'hE700, 16'hE700, 1'b0);
    yq.delete(); d0 = det_cnt;
    send(NPIX, 1'b0, 1'b0, -1); drain();
    check_frame("a", 4, 2, 1'b1, d0, 1'b0, 8'h80);

    // run of 5 too long, single-pixel runs too short
    set_frame(16'hFA80, 16'hFA80, 1'b0);
    yq.delete(); d0 = det_cnt;
    send(NPIX, 1'b0, 1'b0, -1); drain();
    check_frame("b", 0, 0, 1'b0, d0, 1'b0, 8'h80);

    // row 0: runs 2,2,4; rows 1-3: runs of 2 at both row ends
    set_frame(16'hDBC0, 16'hC003, 1'b0);
    yq.delete(); d0 = det_cnt;
    send(NPIX, 1'b0, 1'b0, -1); drain();
    check_frame("c", 4, 3, 1'b1, d0, 1'b0, 8'h80);

    // dark mode on inverted image; mode/threshold flip mid-frame is ignored
    mode = 1'b1; threshold = 8'h80;
    set_frame(16'hE700, 16'hE700, 1'b1);
    yq.delete(); d0 = det_cnt;
    send(NPIX, 1'b0, 1'b0, 20); drain();
    check_frame("d", 4, 2, 1'b1, d0, 1'b1, 8'h80);

    // flipped settings (bright, 0x10) take effect at the next frame
    yq.delete(); d0 = det_cnt;
    send(NPIX, 1'b0, 1'b0, -1); drain();
    check_frame("d2", 0, 1, 1'b0, d0, 1'b0, 8'h10);

    // stalls on both sides must not change anything
    mode = 1'b0; threshold = 8'h80;
    set_frame(16'hE700, 16'hE700, 1'b0);
    yq.delete(); d0 = det_cnt;
    send(NPIX, 1'b1, 1'b0, -1); drain();
    check_frame("e", 4, 2, 1'b1, d0, 1'b0, 8'h80);

    // abort after 30 pixels with a restart carrying the new pixel (0,0)
    d0 = det_cnt;
    send(30, 1'b0, 1'b0, -1); drain();
    check_eq("f_partial_det", det_cnt - d0, 0);
    yq.delete();
    send(NPIX, 1'b0, 1'b1, -1); drain();
    check_frame("f_restart", 4, 2, 1'b1, d0, 1'b0, 8'h80);

    // reset 40 pixels into a frame
    d0 = det_cnt;
    send(40, 1'b0, 1'b0, -1); drain();
    check_eq("f_hold_rows", stripe_rows, 4);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("f_rst_rows", stripe_rows, 0);
    check_eq("f_rst_max", max_stripes, 0);
    check_eq("f_abort_det", det_cnt - d0, 0);
    @(posedge clk);
    #1;
    yq.delete(); d0 = det_cnt;
    send(NPIX, 1'b0, 1'b0, -1); drain();
    check_frame("f_after_rst", 4, 2, 1'b1, d0, 1'b0, 8'h80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
